// File: rtl/axictrl_sched.sv
// Job sequencer for the DDR copy engine: splits one large copy request into
// buffer-sized chunks, runs the engine start/done handshake and a per-chunk watchdog.
module axictrl_sched #(
    parameter int unsigned MAX_CHUNK    = 512,
    parameter int unsigned STRIDE_SHIFT = 4,
    parameter int unsigned GAP_CYCLES   = 2,
    parameter int unsigned TMO_WIDTH    = 16
) (
    input  logic                 I_clk,
    input  logic                 I_rst,
    input  logic                 I_start,
    input  logic                 I_abort,
    input  logic [27:0]          I_base_addr,
    input  logic [31:0]          I_total_len,
    input  logic [TMO_WIDTH-1:0] I_timeout,
    output logic                 O_busy,
    output logic                 O_done,
    output logic                 O_err,
    output logic [15:0]          O_chunk_cnt,
    output logic                 O_ap_start,
    output logic [27:0]          O_base_addr,
    output logic [31:0]          O_len,
    input  logic                 I_ap_done
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_GAP  = 3'd3;
    localparam logic [2:0] S_FIN  = 3'd4;
    localparam logic [2:0] S_ERR  = 3'd5;

    localparam int unsigned      GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [31:0]      MAX_LEN  = 32'(MAX_CHUNK);

    logic [2:0]           state_q, state_d;
    logic [27:0]          addr_q, addr_d;
    logic [31:0]          rem_q, rem_d;
    logic [31:0]          len_q, len_d;
    logic [27:0]          baseOut_q, baseOut_d;
    logic [TMO_WIDTH-1:0] tmo_q, tmo_d;
    logic [TMO_WIDTH-1:0] wdog_q, wdog_d;
    logic [GAP_W-1:0]     gap_q, gap_d;
    logic [15:0]          chunkCnt_q, chunkCnt_d;
    logic                 err_q, err_d;
    logic                 busy_q, done_q, apStart_q;

    logic [31:0] remAfter;
    logic [27:0] stepAddr;

    // len_q doubles as the current chunk size, so the step uses the registered engine length.
    assign remAfter = rem_q - len_q;
    assign stepAddr = addr_q + 28'(len_q << STRIDE_SHIFT);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        len_d      = len_q;
        baseOut_d  = baseOut_q;
        tmo_d      = tmo_q;
        wdog_d     = wdog_q;
        gap_d      = gap_q;
        chunkCnt_d = chunkCnt_q;
        err_d      = err_q;

        if (I_abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (I_start) begin
                        addr_d     = I_base_addr;
                        rem_d      = I_total_len;
                        tmo_d      = I_timeout;
                        chunkCnt_d = '0;
                        err_d      = 1'b0;
                        state_d    = S_LOAD;
                    end
                end
                // A zero-length request also passes through LOAD, which places its done pulse two cycles after start.
                S_LOAD: begin
                    len_d     = (rem_q > MAX_LEN) ? MAX_LEN : rem_q;
                    baseOut_d = addr_q;
                    wdog_d    = '0;
                    state_d   = (rem_q == '0) ? S_FIN : S_RUN;
                end
                S_RUN: begin
                    if (I_ap_done) begin
                        rem_d      = remAfter;
                        addr_d     = stepAddr;
                        chunkCnt_d = (chunkCnt_q == 16'hFFFF) ? chunkCnt_q : chunkCnt_q + 16'd1;
                        gap_d      = '0;
                        state_d    = (remAfter == '0) ? S_FIN : S_GAP;
                    end else begin
                        wdog_d = wdog_q + TMO_WIDTH'(1);
                        if (tmo_q != '0 && wdog_q == tmo_q) begin
                            err_d   = 1'b1;
                            state_d = S_ERR;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_q == GAP_LAST) begin
                        state_d = S_LOAD;
                    end else begin
                        gap_d = gap_q + GAP_W'(1);
                    end
                end
                S_FIN:   state_d = S_IDLE;
                S_ERR:   state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Status outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            len_q      <= '0;
            baseOut_q  <= '0;
            tmo_q      <= '0;
            wdog_q     <= '0;
            gap_q      <= '0;
            chunkCnt_q <= '0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            apStart_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            len_q      <= len_d;
            baseOut_q  <= baseOut_d;
            tmo_q      <= tmo_d;
            wdog_q     <= wdog_d;
            gap_q      <= gap_d;
            chunkCnt_q <= chunkCnt_d;
            err_q      <= err_d;
            busy_q     <= (state_d != S_IDLE);
            done_q     <= (state_d == S_FIN);
            apStart_q  <= (state_d == S_RUN);
        end
    end

    assign O_busy      = busy_q;
    assign O_done      = done_q;
    assign O_err       = err_q;
    assign O_chunk_cnt = chunkCnt_q;
    assign O_ap_start  = apStart_q;
    assign O_base_addr = baseOut_q;
    assign O_len       = len_q;

endmodule

// File: tb/tb_axictrl_sched.sv
// Scoreboard bench for axictrl_sched: a request-level model queues expected engine
// jobs and end-of-request events; a monitor checks them as the DUT produces them.
module tb_axictrl_sched;

    localparam int MAX_CHUNK    = 512;
    localparam int STRIDE_SHIFT = 4;
    localparam int GAP_CYCLES   = 2;
    localparam int TMO_WIDTH    = 16;

    logic                 I_clk;
    logic                 I_rst;
    logic                 I_start;
    logic                 I_abort;
    logic [27:0]          I_base_addr;
    logic [31:0]          I_total_len;
    logic [TMO_WIDTH-1:0] I_timeout;
    logic                 O_busy;
    logic                 O_done;
    logic                 O_err;
    logic [15:0]          O_chunk_cnt;
    logic                 O_ap_start;
    logic [27:0]          O_base_addr;
    logic [31:0]          O_len;
    logic                 I_ap_done;

    typedef enum logic [1:0] {EV_DONE, EV_ERR, EV_ABORT} evKind_t;
    typedef struct {
        logic [27:0] addr;
        logic [31:0] len;
    } job_t;
    typedef struct {
        evKind_t kind;
        int      chunks;
        int      tmo;
        bit      zeroLen;
        int      startCyc;
    } endRec_t;

    job_t    jobQ[$];
    endRec_t endQ[$];

    int checks      = 0;
    int errors      = 0;
    int cyc         = 0;
    int engineDelay = 0;
    bit noiseEn     = 0;
    int abortCyc    = -1;

    axictrl_sched #(
        .MAX_CHUNK   (MAX_CHUNK),
        .STRIDE_SHIFT(STRIDE_SHIFT),
        .GAP_CYCLES  (GAP_CYCLES),
        .TMO_WIDTH   (TMO_WIDTH)
    ) dut (
        .I_clk      (I_clk),
        .I_rst      (I_rst),
        .I_start    (I_start),
        .I_abort    (I_abort),
        .I_base_addr(I_base_addr),
        .I_total_len(I_total_len),
        .I_timeout  (I_timeout),
        .O_busy     (O_busy),
        .O_done     (O_done),
        .O_err      (O_err),
        .O_chunk_cnt(O_chunk_cnt),
        .O_ap_start (O_ap_start),
        .O_base_addr(O_base_addr),
        .O_len      (O_len),
        .I_ap_done  (I_ap_done)
    );

    initial begin
        I_clk = 1'b0;
        forever #5 I_clk = ~I_clk;
    end

    initial begin
        forever begin
            @(posedge I_clk);
            cyc++;
        end
    end

    initial begin
        #500_000;
        $display("[TB] FAIL globalTimeout: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "[TB] global time limit exceeded");
    end

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Request-level model: carve the total length into chunks and predict how the request ends.
    task automatic modelRequest(input logic [27:0] base, input logic [31:0] len, input int tmo,
                                input int delay, input int abortJob, input int startCyc);
        longint  rem;
        longint  off;
        longint  c;
        int      n;
        job_t    j;
        endRec_t r;
        rem        = longint'(len);
        off        = 0;
        n          = 0;
        r.kind     = EV_DONE;
        r.tmo      = tmo;
        r.zeroLen  = (len == 0);
        r.startCyc = startCyc;
        while (rem > 0) begin
            c      = (rem > MAX_CHUNK) ? MAX_CHUNK : rem;
            j.addr = base + 28'(off << STRIDE_SHIFT);
            j.len  = 32'(c);
            jobQ.push_back(j);
            if (abortJob == n) begin
                r.kind = EV_ABORT;
                break;
            end
            if (delay == 0 || (tmo != 0 && delay > tmo)) begin
                r.kind = EV_ERR;
                break;
            end
            rem -= c;
            off += c;
            n++;
        end
        r.chunks = (n > 65535) ? 65535 : n;
        endQ.push_back(r);
    endtask

    task automatic issueStart(input logic [27:0] base, input logic [31:0] len, input int tmo,
                              input int delay, input int abortJob);
        @(posedge I_clk);
        #1;
        engineDelay = delay;
        modelRequest(base, len, tmo, delay, abortJob, cyc);
        I_base_addr = base;
        I_total_len = len;
        I_timeout   = TMO_WIDTH'(tmo);
        I_start     = 1'b1;
        @(posedge I_clk);
        #1;
        I_start     = 1'b0;
        I_base_addr = 28'($urandom);
        I_total_len = $urandom;
        I_timeout   = TMO_WIDTH'($urandom);
    endtask

    task automatic waitIdle(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (!O_busy) return;
            @(posedge I_clk);
            #1;
        end
        checks++;
        errors++;
        $display("[TB] FAIL idleWait: O_busy still %0d after %0d cycles, required 0", O_busy, budget);
        I_rst = 1'b1;
        #1;
        jobQ.delete();
        endQ.delete();
        @(negedge I_clk);
        I_rst = 1'b0;
    endtask

    task automatic applyStimulus(input logic [27:0] base, input logic [31:0] len, input int tmo,
                                 input int delay, input int abortJob, input int abortWait);
        bit found;
        issueStart(base, len, tmo, delay, abortJob);
        if (abortJob >= 0) begin
            found = 0;
            for (int i = 0; i < 2000 && !found; i++) begin
                if (O_chunk_cnt == 16'(abortJob) && O_ap_start) found = 1;
                else begin
                    @(posedge I_clk);
                    #1;
                end
            end
            if (!found) begin
                checks++;
                errors++;
                $display("[TB] FAIL abortWait: chunk %0d never started, O_chunk_cnt=%0d", abortJob, O_chunk_cnt);
            end
            repeat (abortWait) begin
                @(posedge I_clk);
                #1;
            end
            I_abort  = 1'b1;
            abortCyc = cyc;
            @(posedge I_clk);
            #1;
            I_abort = 1'b0;
        end
        waitIdle(3000);
        repeat (2) @(posedge I_clk);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_busy"}, O_busy, 0);
        checkOutput({tag, "_done"}, O_done, 0);
        checkOutput({tag, "_err"}, O_err, 0);
        checkOutput({tag, "_chunkCnt"}, O_chunk_cnt, 0);
        checkOutput({tag, "_apStart"}, O_ap_start, 0);
        checkOutput({tag, "_baseAddr"}, O_base_addr, 0);
        checkOutput({tag, "_len"}, O_len, 0);
    endtask

    // Engine model: completes each job a fixed delay after start; optional junk done pulses while idle.
    initial begin
        int engCnt;
        bit engBusy;
        engCnt    = 0;
        engBusy   = 0;
        I_ap_done = 1'b0;
        forever begin
            @(posedge I_clk);
            #1;
            if (!O_ap_start) begin
                engBusy   = 0;
                I_ap_done = noiseEn && ($urandom_range(0, 3) == 0);
            end else begin
                if (!engBusy) begin
                    engBusy = 1;
                    engCnt  = 0;
                end else begin
                    engCnt++;
                end
                I_ap_done = (engineDelay > 0) && (engCnt == engineDelay);
            end
        end
    end

    // Monitor: pops expected jobs on each start rise and expected endings when busy drops.
    initial begin
        bit      prevAp;
        bit      prevBusy;
        bit      jobSeen;
        int      hiCnt;
        int      lowCnt;
        int      doneCnt;
        int      doneCyc;
        int      lastApCyc;
        job_t    j;
        endRec_t r;
        evKind_t k;
        prevAp    = 0;
        prevBusy  = 0;
        jobSeen   = 0;
        hiCnt     = 0;
        lowCnt    = 0;
        doneCnt   = 0;
        doneCyc   = 0;
        lastApCyc = 0;
        forever begin
            @(negedge I_clk);
            if (I_rst) begin
                prevAp   = 0;
                prevBusy = 0;
                jobSeen  = 0;
                doneCnt  = 0;
                continue;
            end
            if (O_busy && !prevBusy) begin
                checkOutput("errClearedOnStart", O_err, 0);
                checkOutput("cntClearedOnStart", O_chunk_cnt, 0);
                doneCnt = 0;
                jobSeen = 0;
            end
            if (O_ap_start && !prevAp) begin
                if (jobQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpectedJob: start at base 0x%0h len %0d, none expected", O_base_addr, O_len);
                end else begin
                    j = jobQ.pop_front();
                    checkOutput("jobBaseAddr", O_base_addr, j.addr);
                    checkOutput("jobLen", O_len, j.len);
                end
                // Between chunks start stays low for the gap cycles plus the LOAD cycle.
                if (jobSeen) checkOutput("gapLowCycles", lowCnt, GAP_CYCLES + 1);
                jobSeen = 1;
                hiCnt   = 0;
            end
            if (O_ap_start) begin
                hiCnt++;
                lastApCyc = cyc;
            end
            if (!O_ap_start && prevAp) lowCnt = 1;
            else if (!O_ap_start) lowCnt++;
            if (O_done) begin
                doneCnt++;
                doneCyc = cyc;
            end
            if (!O_busy && prevBusy) begin
                if (endQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpectedEnd: busy dropped with no request outstanding, done=%0d err=%0d", doneCnt, O_err);
                end else begin
                    r = endQ.pop_front();
                    k = (doneCnt > 0) ? EV_DONE : (O_err ? EV_ERR : EV_ABORT);
                    checkOutput("endKind", k, r.kind);
                    checkOutput("chunkCount", O_chunk_cnt, r.chunks);
                    checkOutput("donePulses", doneCnt, (r.kind == EV_DONE) ? 1 : 0);
                    checkOutput("jobsAllIssued", jobQ.size(), 0);
                    case (r.kind)
                        EV_DONE: begin
                            checkOutput("busyDropAfterDone", cyc - doneCyc, 1);
                            if (r.zeroLen) begin
                                checkOutput("zeroLenDoneLatency", doneCyc - r.startCyc, 2);
                                checkOutput("zeroLenNoStart", jobSeen, 0);
                            end else begin
                                checkOutput("doneAfterLastStart", doneCyc - lastApCyc, 1);
                            end
                        end
                        EV_ERR:   checkOutput("watchdogHighCycles", hiCnt, r.tmo + 1);
                        default:  checkOutput("abortLatency", cyc - abortCyc, 1);
                    endcase
                end
                jobQ.delete();
            end
            prevAp   = O_ap_start;
            prevBusy = O_busy;
        end
    end

    initial begin
        logic [27:0] base;
        logic [31:0] len;
        int          delay;
        int          tmo;
        int          sel;
        I_rst       = 1'b1;
        I_start     = 1'b0;
        I_abort     = 1'b0;
        I_base_addr = '0;
        I_total_len = '0;
        I_timeout   = '0;
        @(negedge I_clk);
        checkAllZero("resetState");
        repeat (2) @(negedge I_clk);
        I_rst = 1'b0;

        applyStimulus(28'h100, 32'd100, 0, 50, -1, 0);
        applyStimulus(28'h0, 32'd1200, 0, 15, -1, 0);
        applyStimulus(28'h40, 32'd0, 0, 5, -1, 0);
        applyStimulus(28'h200, 32'd40, 20, 0, -1, 0);
        checkOutput("errSticky", O_err, 1);
        applyStimulus(28'h300, 32'd10, 0, 8, -1, 0);
        checkOutput("errClearedAfterRequest", O_err, 0);
        applyStimulus(28'h1000, 32'd1200, 0, 20, 1, 6);

        // Asynchronous reset between clock edges in the middle of a chunk.
        issueStart(28'h800, 32'd1200, 0, 30, -1);
        for (int i = 0; i < 20 && !O_ap_start; i++) begin
            @(posedge I_clk);
            #1;
        end
        repeat (5) begin
            @(posedge I_clk);
            #1;
        end
        #2;
        I_rst = 1'b1;
        #1;
        checkAllZero("asyncReset");
        jobQ.delete();
        endQ.delete();
        repeat (2) @(negedge I_clk);
        I_rst = 1'b0;
        applyStimulus(28'h500, 32'd700, 0, 12, -1, 0);

        noiseEn = 1;
        for (int i = 0; i < 12; i++) begin
            base = (i % 3 == 0) ? 28'hFFFFE00 + 28'($urandom_range(0, 255)) : 28'($urandom);
            sel  = $urandom_range(0, 5);
            case (sel)
                0:       len = 32'd0;
                1:       len = 32'd512;
                2:       len = 32'd513;
                3:       len = 32'd1024;
                default: len = 32'($urandom_range(1, 1600));
            endcase
            delay = $urandom_range(1, 30);
            sel   = $urandom_range(0, 2);
            if (sel == 1)                      tmo = delay + $urandom_range(0, 3);
            else if (sel == 2 && delay > 1)    tmo = $urandom_range(1, delay - 1);
            else                               tmo = 0;
            applyStimulus(base, len, tmo, delay, -1, 0);
        end
        noiseEn = 0;

        repeat (3) @(posedge I_clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
